// File: rtl/trail_pattern_gen.sv
// trail_pattern_gen
//   Phosphor-trail VGA pattern generator. It takes beam coordinates and vsync
//   from hvsync_generator and produces registered 2-bit R/G/B for the Tiny VGA
//   Pmod. A frame counter advances on vsync rising edges, optionally through a
//   divider. Each of the last N_LAG frames is compared against the beam
//   position. The youngest matching age picks a fade level, and the palette
//   maps that level to colour.
//
//   Optional feature macro: TRAIL_STEP_EN
//     defined   : pause / single-step control with a pending-step flag.
//     undefined : pause and step are ignored and the counter free-runs.
//
// Ports
//   clk, rst_n        pixel clock, async active-low reset
//   hpos, vpos [9:0]  beam position
//   vsync             vsync, synchronous to clk
//   mode [1:0]        00 XOR, 01 SUM, 10 DIFF, 11 XOR
//   palette [1:0]     00 amber/cyan, 01 green, 10 mono, 11 inverse
//   pause, step       freeze / single-step (TRAIL_STEP_EN only)
//   r, g, b [1:0]     registered colour (1 clk latency)
//   frame_no          current frame counter

// Per-age comparator. There is one instance per trail age, so AGE is a
// constant offset from the current frame.
module trail_age_cmp #(
  parameter int COORD_W = 9,
  parameter int AGE     = 0
) (
  input  logic [COORD_W-1:0] frame_no,
  input  logic [COORD_W-1:0] h,
  input  logic [COORD_W-1:0] v,
  input  logic [1:0]         mode,
  output logic               hit
);
  localparam logic [COORD_W-1:0] AGE_C = COORD_W'(AGE);

  logic [COORD_W-1:0] f, x_v, s_v, d_v;

  assign f   = frame_no - AGE_C;   // wraps mod 2^COORD_W
  assign x_v = v ^ f;
  assign s_v = v + f;
  assign d_v = v - f;

  always_comb begin
    hit = 1'b0;
    case (mode)
      2'b01:   hit = (h == s_v);
      2'b10:   hit = (h == d_v);
      default: hit = (h == x_v);   // 00 and 11 are both XOR
    endcase
  end
endmodule

module trail_pattern_gen #(
  parameter int N_LAG     = 15,
  parameter int COORD_W   = 9,
  parameter int ACTIVE_W  = 512,
  parameter int ACTIVE_H  = 480,
  parameter int FRAME_DIV = 1,
  parameter int T_HI      = 3,
  parameter int T_MID     = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  input  logic               vsync,
  input  logic [1:0]         mode,
  input  logic [1:0]         palette,
  input  logic               pause,
  input  logic               step,
  output logic [1:0]         r,
  output logic [1:0]         g,
  output logic [1:0]         b,
  output logic [COORD_W-1:0] frame_no
);

  // Parameter legality is checked at elaboration.
  if (N_LAG < 1 || N_LAG > 32) begin : g_bad_nlag
    $error("trail_pattern_gen: N_LAG must be 1..32");
  end
  if (FRAME_DIV < 1 || FRAME_DIV > 16) begin : g_bad_div
    $error("trail_pattern_gen: FRAME_DIV must be 1..16");
  end
  if (T_HI > T_MID) begin : g_bad_thr
    $error("trail_pattern_gen: T_HI must not exceed T_MID");
  end
  if (COORD_W < 1 || COORD_W > 10) begin : g_bad_cw
    $error("trail_pattern_gen: COORD_W must be 1..10");
  end

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int AGE_W = 5;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  // ---------------------------------------------------------------------------
  // Frame tick and counter
  // ---------------------------------------------------------------------------
  logic             vs_q;
  logic             vs_lo_seen;  // vsync has been sampled low since reset
  logic             tick;
  logic [DIV_W-1:0] div_cnt;

  // vs_q resets low. Without vs_lo_seen, a vsync that is already high at
  // reset release would look like a rising edge.
  assign tick = vsync & ~vs_q & vs_lo_seen;

`ifdef TRAIL_STEP_EN
  logic step_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q       <= 1'b0;
      vs_lo_seen <= 1'b0;
      div_cnt    <= '0;
      frame_no   <= '0;
      step_pend  <= 1'b0;
    end else begin
      vs_q       <= vsync;
      vs_lo_seen <= vs_lo_seen | ~vsync;
      if (pause) begin
        // A paused tick only advances when a step is pending. In that case
        // the counter moves by one and the divider is left untouched.
        if (tick && step_pend) begin
          frame_no  <= frame_no + 1'b1;
          step_pend <= 1'b0;
        end else if (step) begin
          step_pend <= 1'b1;
        end
      end else begin
        step_pend <= 1'b0;
        if (tick) begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            frame_no <= frame_no + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      end
    end
  end
`else
  logic unused_ctl;
  assign unused_ctl = ^{pause, step};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q       <= 1'b0;
      vs_lo_seen <= 1'b0;
      div_cnt    <= '0;
      frame_no   <= '0;
    end else begin
      vs_q       <= vsync;
      vs_lo_seen <= vs_lo_seen | ~vsync;
      if (tick) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt  <= '0;
          frame_no <= frame_no + 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Per-age compare, one lane per age
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] h, v;
  logic [N_LAG-1:0]   hit;

  assign h = hpos[COORD_W-1:0];
  assign v = vpos[COORD_W-1:0];

  for (genvar k = 0; k < N_LAG; k++) begin : g_age
    trail_age_cmp #(.COORD_W(COORD_W), .AGE(k)) u_cmp (
      .frame_no (frame_no),
      .h        (h),
      .v        (v),
      .mode     (mode),
      .hit      (hit[k])
    );
  end

  // Youngest age wins. The loop scans from oldest to youngest so the
  // lowest matching k is the one left in age.
  logic             any_hit;
  logic [AGE_W-1:0] age;

  always_comb begin
    any_hit = 1'b0;
    age     = '0;
    for (int k = N_LAG - 1; k >= 0; k--) begin
      if (hit[k]) begin
        any_hit = 1'b1;
        age     = AGE_W'(k);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fade level and head flag
  // ---------------------------------------------------------------------------
  logic [1:0] lvl;
  logic       head;

  always_comb begin
    lvl  = 2'd0;
    head = 1'b0;
    if (any_hit) begin
      if (age == '0) begin
        lvl  = 2'd3;
        head = 1'b1;
      end else if (int'(age) < T_HI) begin
        lvl = 2'd3;
      end else if (int'(age) < T_MID) begin
        lvl = 2'd2;
      end else begin
        lvl = 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Palette, blanking, output register
  // ---------------------------------------------------------------------------
  logic       active;
  logic [1:0] r_d, g_d, b_d;

  assign active = (int'(hpos) < ACTIVE_W) && (int'(vpos) < ACTIVE_H);

  always_comb begin
    r_d = 2'd0;
    g_d = 2'd0;
    b_d = 2'd0;
    if (active) begin
      case (palette)
        2'b00: begin
          // amber trail, cyan head
          r_d = head ? 2'd0 : lvl;
          g_d = lvl;
          b_d = head ? lvl : 2'd0;
        end
        2'b01: g_d = lvl;
        2'b10: begin
          r_d = lvl;
          g_d = lvl;
          b_d = lvl;
        end
        default: begin
          // inverse: the background is white and trails darken it
          r_d = 2'd3 - lvl;
          g_d = 2'd3 - lvl;
          b_d = 2'd3 - lvl;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= 2'd0;
      g <= 2'd0;
      b <= 2'd0;
    end else begin
      r <= r_d;
      g <= g_d;
      b <= b_d;
    end
  end

endmodule

// File: tb/tb_trail_pattern_gen.sv
module tb_trail_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hpos, vpos;
  logic       vsync;
  logic [1:0] mode, palette;
  logic       pause, step;
  logic [1:0] r, g, b;
  logic [8:0] frame_no;
  logic [1:0] r4, g4, b4;
  logic [8:0] frame_no4;

  always #5 clk = ~clk;

  trail_pattern_gen dut (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .vsync(vsync),
    .mode(mode), .palette(palette), .pause(pause), .step(step),
    .r(r), .g(g), .b(b), .frame_no(frame_no)
  );

  trail_pattern_gen #(.FRAME_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .vsync(vsync),
    .mode(mode), .palette(palette), .pause(pause), .step(step),
    .r(r4), .g(g4), .b(b4), .frame_no(frame_no4)
  );

  typedef struct {
    int         frame;
    logic [9:0] h;
    logic [9:0] v;
    logic [1:0] mode;
    logic [1:0] pal;
    logic [5:0] rgb;
  } vec_t;

  typedef struct {
    int         idx;
    logic [5:0] rgb;
  } exp_t;

  localparam int NV = 30;
  vec_t vtab[NV];
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_frame = 0;
  int ticks = 0;

  function automatic vec_t mk(int f, int h, int v, int m, int p,
                              int er, int eg, int eb);
    vec_t t;
    t.frame = f;
    t.h     = 10'(h);
    t.v     = 10'(v);
    t.mode  = 2'(m);
    t.pal   = 2'(p);
    t.rgb   = {2'(er), 2'(eg), 2'(eb)};
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One pixel cycle: compare the output due from the previous drive, then
  // optionally drive a new vector and queue its expectation.
  task automatic pix_step(input bit drive, input int i);
    exp_t e;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({r, g, b} !== e.rgb) begin
        n_fail++;
        $display("FAIL pix[%0d]: got rgb=%b expected %b", e.idx, {r, g, b}, e.rgb);
      end
    end
    if (drive) begin
      hpos    = vtab[i].h;
      vpos    = vtab[i].v;
      mode    = vtab[i].mode;
      palette = vtab[i].pal;
      e.idx   = i;
      e.rgb   = vtab[i].rgb;
      sb.push_back(e);
    end
  endtask

  // n vsync pulses. The model counter advances only if adv is set.
  task automatic do_ticks(input int n, input bit adv);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); vsync = 1'b1;
      @(negedge clk); vsync = 1'b0;
      ticks++;
      if (adv) exp_frame++;
    end
  endtask

  task automatic pulse_step();
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
  endtask

  initial begin
    vtab[0]  = mk(0, 0, 0, 1, 0, 0, 3, 3);
    vtab[1]  = mk(0, 3, 3, 0, 2, 3, 3, 3);
    vtab[2]  = mk(0, 100, 480, 0, 3, 0, 0, 0);
    vtab[3]  = mk(0, 511, 511, 1, 3, 0, 0, 0);
    vtab[4]  = mk(0, 512, 0, 0, 3, 0, 0, 0);
    vtab[5]  = mk(0, 0, 0, 2, 1, 0, 3, 0);
    vtab[6]  = mk(0, 1, 0, 2, 0, 3, 3, 0);
    vtab[7]  = mk(0, 5, 0, 2, 0, 2, 2, 0);
    vtab[8]  = mk(5, 7, 2, 0, 0, 0, 3, 3);
    vtab[9]  = mk(5, 6, 2, 0, 0, 3, 3, 0);
    vtab[10] = mk(5, 2, 2, 0, 1, 0, 2, 0);
    vtab[11] = mk(5, 2, 2, 0, 3, 1, 1, 1);
    vtab[12] = mk(5, 100, 2, 0, 3, 3, 3, 3);
    vtab[13] = mk(5, 7, 2, 3, 2, 3, 3, 3);
    vtab[14] = mk(5, 7, 2, 1, 0, 0, 3, 3);
    vtab[15] = mk(5, 7, 10, 2, 2, 3, 3, 3);
    vtab[16] = mk(5, 9, 10, 2, 2, 2, 2, 2);
    vtab[17] = mk(5, 7, 2, 0, 3, 0, 0, 0);
    vtab[18] = mk(20, 16, 0, 0, 2, 2, 2, 2);
    vtab[19] = mk(20, 10, 0, 0, 2, 1, 1, 1);
    vtab[20] = mk(20, 5, 0, 0, 2, 0, 0, 0);
    vtab[21] = mk(20, 14, 0, 0, 2, 2, 2, 2);
    vtab[22] = mk(20, 13, 0, 0, 2, 1, 1, 1);
    vtab[23] = mk(20, 6, 0, 0, 2, 1, 1, 1);
    vtab[24] = mk(20, 18, 0, 0, 2, 3, 3, 3);
    vtab[25] = mk(20, 17, 0, 0, 2, 2, 2, 2);
    vtab[26] = mk(40, 7, 479, 1, 0, 0, 3, 3);
    vtab[27] = mk(40, 7, 480, 1, 3, 0, 0, 0);
    vtab[28] = mk(40, 6, 479, 1, 0, 3, 3, 0);
    vtab[29] = mk(40, 7, 479, 1, 3, 0, 0, 0);

    rst_n = 1'b0; hpos = '0; vpos = '0; vsync = 1'b0;
    mode = '0; palette = 2'd3; pause = 1'b0; step = 1'b0;
    #23;
    chk("reset_rgb", int'({r, g, b}), 0);
    chk("reset_frame", int'(frame_no), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven pixel vectors, grouped by frame number.
    for (int i = 0; i < NV; i++) begin
      if (vtab[i].frame != exp_frame) begin
        pix_step(1'b0, 0);
        do_ticks(vtab[i].frame - exp_frame, 1'b1);
        @(negedge clk);
        chk("frame_group", int'(frame_no), exp_frame);
      end
      pix_step(1'b1, i);
    end
    pix_step(1'b0, 0);
    chk("frame_40", int'(frame_no), 40);
    chk("div4_40ticks", int'(frame_no4), ticks / 4);

    // Asynchronous reset mid-line with nonzero outputs.
    hpos = 10'd100; vpos = 10'd2; mode = 2'd0; palette = 2'd3;
    @(negedge clk);
    chk("pre_reset_rgb", int'({r, g, b}), 63);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_rgb", int'({r, g, b}), 0);
    chk("async_reset_frame", int'(frame_no), 0);
    chk("async_reset_frame4", int'(frame_no4), 0);
    @(negedge clk); rst_n = 1'b1;
    exp_frame = 0; ticks = 0;
    repeat (2) @(negedge clk);
    do_ticks(3, 1'b1);
    @(negedge clk);
    chk("three_ticks", int'(frame_no), 3);
    chk("div4_3ticks", int'(frame_no4), 0);
    do_ticks(6, 1'b1);
    @(negedge clk);
    chk("nine_ticks", int'(frame_no), 9);
    chk("div4_9ticks", int'(frame_no4), 2);

    // vsync already high at reset release must not count as a tick.
    @(negedge clk); rst_n = 1'b0; vsync = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("vsync_high_release", int'(frame_no), 0);
    @(negedge clk); vsync = 1'b0;
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
    @(negedge clk);
    chk("first_tick_after_low", int'(frame_no), 1);
    exp_frame = 1;

`ifdef TRAIL_STEP_EN
    pause = 1'b1;
    do_ticks(5, 1'b0);
    @(negedge clk);
    chk("paused_hold", int'(frame_no), exp_frame);
    pulse_step(); pulse_step(); pulse_step();
    @(negedge clk);
    chk("step_waits_tick", int'(frame_no), exp_frame);
    do_ticks(1, 1'b1);
    do_ticks(1, 1'b0);
    @(negedge clk);
    chk("step_one_frame", int'(frame_no), exp_frame);
    // A pending step is dropped when pause is released.
    pulse_step();
    @(negedge clk); pause = 1'b0;
    @(negedge clk); pause = 1'b1;
    do_ticks(1, 1'b0);
    @(negedge clk);
    chk("pend_cleared", int'(frame_no), exp_frame);
    pause = 1'b0;
    pulse_step();
    @(negedge clk);
    chk("step_unpaused", int'(frame_no), exp_frame);
    do_ticks(1, 1'b1);
    @(negedge clk);
    chk("resume_count", int'(frame_no), exp_frame);
`else
    pause = 1'b1;
    pulse_step();
    do_ticks(2, 1'b1);
    @(negedge clk);
    chk("pause_ignored", int'(frame_no), exp_frame);
    pause = 1'b0;
    pulse_step();
    @(negedge clk);
    chk("step_ignored", int'(frame_no), exp_frame);
`endif

    if (sb.size() != 0) chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trail_pattern_gen.md
# trail_pattern_gen

Parametrised phosphor-trail VGA pattern generator, successor to the fixed 15-deep XOR trail in the top level. It sits between `hvsync_generator` and the Tiny VGA Pmod pin mapping, taking beam coordinates and vsync and producing registered 2-bit R/G/B. It advances its own frame counter synchronously in the `clk` domain, selects among three coordinate patterns, supports palettes and optional pause/single-step, and fades each trail over a configurable number of frames.

## Interface
- `N_LAG`, 15, trail depth in frames (1..32); age 0 is the head.
- `COORD_W`, 9, bits of hpos/vpos/frame counter used in the compare.
- `ACTIVE_W`, 512, pixels per line drawn; columns at or beyond this are black.
- `ACTIVE_H`, 480, lines drawn; lines at or beyond this are black.
- `FRAME_DIV`, 1, vsync rising edges per frame-counter step (1..16).
- `T_HI`, 3, ages 1..T_HI-1 render at level 3.
- `T_MID`, 7, ages T_HI..T_MID-1 render at level 2; older ages render at level 1.
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `hpos` in 10: beam X from `hvsync_generator`.
- `vpos` in 10: beam Y from `hvsync_generator`.
- `vsync` in 1: vsync from `hvsync_generator`, synchronous to `clk`.
- `mode` in 2: pattern select. 00 XOR, 01 SUM, 10 DIFF, 11 XOR.
- `palette` in 2: 00 amber/cyan, 01 green, 10 mono, 11 inverse.
- `pause` in 1: freeze the frame counter (only with `TRAIL_STEP_EN`).
- `step` in 1: one-cycle pulse, advance one frame while paused (only with `TRAIL_STEP_EN`).
- `r`, `g`, `b` out 2 each: registered colour.
- `frame_no` out COORD_W: current frame counter.

## Operation
- **Frame tick:** `vsync` is registered as `vs_q`. A tick is `vsync & ~vs_q`.
- **Divider:** a divider counts ticks 0..FRAME_DIV-1. `frame_no` increments when the divider wraps and the counter is not frozen. `frame_no` wraps mod 2^COORD_W.
- **Per-age compare:** for each age k in 0..N_LAG-1, with `f = (frame_no - k) mod 2^COORD_W` and `h`, `v` = low COORD_W bits of hpos/vpos:
  - XOR: `h == v ^ f`
  - SUM: `h == (v + f) mod 2^COORD_W`
  - DIFF: `h == (v - f) mod 2^COORD_W`
- **Age selection:** the youngest matching age wins (priority encoder, lowest k). No match gives level 0.
- **Level:** age 0 is level 3 with the head flag set. Age < T_HI is level 3, age < T_MID is level 2, otherwise level 1. Head flag is 0 for every age > 0.
- **Palette, with L = level:**
  - amber/cyan: tail R=G=L, B=0; head R=0, G=B=L.
  - green: G=L only.
  - mono: R=G=B=L.
  - inverse: R=G=B=3-L inside the active area.
- **Blanking:** outside `hpos < ACTIVE_W && vpos < ACTIVE_H`, all outputs are 0 in every palette.
- **Pause/step (`TRAIL_STEP_EN`):**
  - While `pause`=1, the divider and `frame_no` hold.
  - `step` while paused sets `step_pend`. The next tick advances `frame_no` by exactly 1 and clears `step_pend`, regardless of the divider.
  - Further `step` pulses before that tick are absorbed.
  - `step` while not paused is ignored.
  - Deasserting `pause` clears `step_pend`.

## Timing
- **Latency:** `hpos`/`vpos`/`mode`/`palette` to `r/g/b` is 1 clk (single output register).
- **Counter update:** `frame_no` updates on the clk edge that detects the tick, i.e. one cycle after the `vsync` rising edge is sampled.
- **Reset values:** `r=g=b=0`, `frame_no=0`, `vs_q=0`, divider 0, `step_pend=0`. These apply immediately and asynchronously. The first tick is detected only after `vsync` is seen low and then high following reset release.
- **Mid-frame control changes:** `mode` or `palette` changes take effect on the next pixel. `pause` asserted in the same cycle as a tick blocks that advance.
- **Parameter legality:** `N_LAG`, `FRAME_DIV` and `T_HI ≤ T_MID` out of range are an elaboration error.

## Configuration
- **`TRAIL_STEP_EN`:**
  - Defined: pause/step logic and `step_pend` are built.
  - Undefined: `pause` and `step` are ignored (tied into an unused-signal reduction) and `frame_no` free-runs on the divider.

## Test plan
- **Reset:** assert `rst_n`=0 mid-line. Required: `r/g/b` = 0 and `frame_no` = 0 in the same cycle without a clk edge. Release, then 3 vsync pulses with FRAME_DIV=1. Required: `frame_no`=3.
- **XOR head, amber:** XOR, amber, `frame_no`=5, vpos=2. At hpos=7 (2^5), required: R=0, G=B=3 one clk later. At hpos=6 (age 1, 2^4), required: R=G=3, B=0.
- **Fade levels:** mono, `frame_no`=20, vpos=0. Required: hpos=16 (age 4) gives 2/2/2; hpos=10 (age 10) gives 1/1/1; hpos=5 (age 15, N_LAG=15) gives 0.
- **SUM wrap and blanking:** SUM, `frame_no`=0, vpos=511 gives a head at hpos=511. Required: same coordinates at vpos=480 give 0 in inverse palette.
- **Divider:** FRAME_DIV=4, 9 ticks from reset. Required: `frame_no`=2.
- **Pause/step (`TRAIL_STEP_EN`):** `pause`=1, 5 ticks, then 3 `step` pulses, then 2 ticks. Required: `frame_no` rises by exactly 1. A `step` with `pause`=0 changes nothing beyond normal counting.
